vga_pattern_gen: RTL and testbench

Pixel-generation stage directly downstream of the VGA sync/timing top. Consumes the pixel coordinates, display-active flag and sync pulses produced by the timing counters. Produces a registered 12-bit RGB pixel stream plus delay-matched sync and data-enable outputs. Four selectable test patterns; the pattern switches only at frame boundaries so no frame is ever torn.

---
 rtl/vga_pattern_gen.sv | 187 ++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test-pattern generator, 2-stage pipeline; PATGEN_BOX_EN enables the moving-box pattern
module vga_pattern_gen #(
    parameter int BOX_SIZE        = 32,
    parameter int BOX_STEP        = 2,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        disp_active,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] h_visible,
    input  logic [11:0] v_visible,
    input  logic [11:0] bar_width,
    input  logic [1:0]  pat_sel,
    input  logic [11:0] solid_rgb,
    output logic [11:0] rgb,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic        frame_start
);

    localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [11:0] x1;
    logic [11:0] y1;
    logic [11:0] solid1;
    logic        de1;
    logic        hs1;
    logic        vs1;
    logic        vs_prev;
    logic        vs_on;
    logic [1:0]  pat_q;
    logic [11:0] bar_cnt;
    logic [2:0]  bar_idx;
    logic [11:0] pix;

    assign vs_on = (vsync_in == SYNC_ON);

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 12'hFFF;
            3'd1:    bar_colour = 12'hFF0;
            3'd2:    bar_colour = 12'h0FF;
            3'd3:    bar_colour = 12'h0F0;
            3'd4:    bar_colour = 12'hF0F;
            3'd5:    bar_colour = 12'hF00;
            3'd6:    bar_colour = 12'h00F;
            default: bar_colour = 12'h000;
        endcase
    endfunction

    // Stage 1: capture coordinates, sync and the solid colour for the pixel being coloured
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1     <= 12'd0;
            y1     <= 12'd0;
            solid1 <= 12'h000;
            de1    <= 1'b0;
            hs1    <= SYNC_OFF;
            vs1    <= SYNC_OFF;
        end else begin
            x1     <= xpos;
            y1     <= ypos;
            solid1 <= solid_rgb;
            de1    <= disp_active;
            hs1    <= hsync_in;
            vs1    <= vsync_in;
        end
    end

    // Leading-edge detect on vsync; vs_prev resets "asserted" so a pulse in progress at release is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_prev     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vs_prev     <= vs_on;
            frame_start <= vs_on && !vs_prev;
        end
    end

    // Pattern select only changes at a frame boundary so a frame is never torn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= 2'd0;
        end else if (frame_start) begin
            pat_q <= pat_sel;
        end
    end

    // Colour-bar position tracks the stage-1 pixel; cleared on every blanking cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_cnt <= 12'd0;
            bar_idx <= 3'd0;
        end else if (!de1) begin
            bar_cnt <= 12'd0;
            bar_idx <= 3'd0;
        end else if (bar_cnt == bar_width - 12'd1) begin
            bar_cnt <= 12'd0;
            if (bar_idx != 3'd7) begin
                bar_idx <= bar_idx + 3'd1;
            end
        end else begin
            bar_cnt <= bar_cnt + 12'd1;
        end
    end

`ifdef PATGEN_BOX_EN
    logic [11:0] box_x;
    logic [11:0] box_y;
    logic        dir_x;
    logic        dir_y;
    logic        in_box;

    // Returns {dir, pos} for the next frame; dir 0 moves toward larger coordinates
    function automatic logic [12:0] box_next(input logic [11:0] pos, input logic dir,
                                             input logic [11:0] vis);
        logic [12:0] far_edge;
        far_edge = {1'b0, pos} + 13'(BOX_SIZE + BOX_STEP);
        if (!dir) begin
            if (far_edge > {1'b0, vis}) box_next = {1'b1, pos - 12'(BOX_STEP)};
            else                        box_next = {1'b0, pos + 12'(BOX_STEP)};
        end else begin
            if (pos < 12'(BOX_STEP))    box_next = {1'b0, pos + 12'(BOX_STEP)};
            else                        box_next = {1'b1, pos - 12'(BOX_STEP)};
        end
    endfunction

    // Box advances once per frame and bounces off the visible-area edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            box_x <= 12'd0;
            box_y <= 12'd0;
            dir_x <= 1'b0;
            dir_y <= 1'b0;
        end else if (frame_start) begin
            {dir_x, box_x} <= box_next(box_x, dir_x, h_visible);
            {dir_y, box_y} <= box_next(box_y, dir_y, v_visible);
        end
    end

    assign in_box = ({1'b0, x1} >= {1'b0, box_x}) &&
                    ({1'b0, x1} <  {1'b0, box_x} + 13'(BOX_SIZE)) &&
                    ({1'b0, y1} >= {1'b0, box_y}) &&
                    ({1'b0, y1} <  {1'b0, box_y} + 13'(BOX_SIZE));
`else
    logic unused_box;
    assign unused_box = ^{h_visible, v_visible, x1[11:6], x1[4:0], y1[11:6], y1[4:0]};
`endif

    // Pattern colour for the stage-1 pixel
    always_comb begin
        pix = 12'h000;
        case (pat_q)
            2'd0:    pix = solid1;
            2'd1:    pix = bar_colour(bar_idx);
            2'd2:    pix = (x1[5] ^ y1[5]) ? 12'hFFF : 12'h000;
`ifdef PATGEN_BOX_EN
            default: pix = in_box ? 12'hF00 : 12'h00F;
`else
            default: pix = 12'h888;
`endif
        endcase
    end

    // Stage 2: registered pixel with blanking applied, plus delay-matched sync and DE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb     <= 12'h000;
            de_o    <= 1'b0;
            hsync_o <= SYNC_OFF;
            vsync_o <= SYNC_OFF;
        end else begin
            rgb     <= de1 ? pix : 12'h000;
            de_o    <= de1;
            hsync_o <= hs1;
            vsync_o <= vs1;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - scoreboard bench for vga_pattern_gen with a frame-level reference model
module tb_vga_pattern_gen;

    localparam int HV       = 48;
    localparam int VV       = 40;
    localparam int HT       = 60;
    localparam int VT       = 44;
    localparam int BOX_SIZE = 32;
    localparam int BOX_STEP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        disp_active;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] h_visible;
    logic [11:0] v_visible;
    logic [11:0] bar_width;
    logic [1:0]  pat_sel;
    logic [11:0] solid_rgb;
    logic [11:0] rgb;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;
    logic        frame_start;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .BOX_SIZE(BOX_SIZE),
        .BOX_STEP(BOX_STEP),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .xpos(xpos),
        .ypos(ypos),
        .disp_active(disp_active),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .h_visible(h_visible),
        .v_visible(v_visible),
        .bar_width(bar_width),
        .pat_sel(pat_sel),
        .solid_rgb(solid_rgb),
        .rgb(rgb),
        .hsync_o(hsync_o),
        .vsync_o(vsync_o),
        .de_o(de_o),
        .frame_start(frame_start)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    int m_pat;
    int m_bx;
    int m_by;
    bit m_dx;
    bit m_dy;
    int m_barpix;
    bit m_prev_vs_on;
    bit in_reset;
    bit rel_pend;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic box_axis(inout int pos, inout bit dir, input int vis);
        if (!dir) begin
            if (pos + BOX_SIZE + BOX_STEP > vis) begin dir = 1'b1; pos -= BOX_STEP; end
            else pos += BOX_STEP;
        end else begin
            if (pos < BOX_STEP) begin dir = 1'b0; pos += BOX_STEP; end
            else pos -= BOX_STEP;
        end
    endtask

    function automatic logic [11:0] model_pix(input int x, input int y);
        int idx;
        case (m_pat)
            0: return solid_rgb;
            1: begin
                idx = m_barpix / int'(bar_width);
                if (idx > 7) idx = 7;
                return bar_tab[idx];
            end
            2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 12'hFFF : 12'h000;
            default: begin
`ifdef PATGEN_BOX_EN
                if (x >= m_bx && x < m_bx + BOX_SIZE && y >= m_by && y < m_by + BOX_SIZE)
                    return 12'hF00;
                return 12'h00F;
`else
                return 12'h888;
`endif
            end
        endcase
    endfunction

    task automatic model_reset();
        m_pat        = 0;
        m_bx         = 0;
        m_by         = 0;
        m_dx         = 1'b0;
        m_dy         = 1'b0;
        m_barpix     = 0;
        m_prev_vs_on = 1'b1;
    endtask

    task automatic drive_pixel(input int x, input int y);
        bit   de;
        bit   hs_on;
        bit   vs_on;
        exp_t e;
        @(negedge clk);
        if (rel_pend) begin
            rst      = 1'b1;
            rel_pend = 1'b0;
            in_reset = 1'b0;
            model_reset();
        end
        de    = (x < HV) && (y < VV);
        hs_on = (x >= HV + 3) && (x < HV + 8);
        vs_on = (y >= VV + 1) && (y < VV + 3);
        xpos        = 12'(x);
        ypos        = 12'(y);
        disp_active = de;
        hsync_in    = ~hs_on;
        vsync_in    = ~vs_on;
        if (!in_reset) begin
            if (vs_on && !m_prev_vs_on) begin
                if (sb.size() > 0) sb[sb.size() - 1].fs = 1'b1;
                m_pat = int'(pat_sel);
                box_axis(m_bx, m_dx, int'(h_visible));
                box_axis(m_by, m_dy, int'(v_visible));
            end
            m_prev_vs_on = vs_on;
            e.rgb = de ? model_pix(x, y) : 12'h000;
            e.hs  = ~hs_on;
            e.vs  = ~vs_on;
            e.de  = de;
            e.fs  = 1'b0;
            if (de) m_barpix++;
            else    m_barpix = 0;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset_check();
        @(posedge clk);
        #3;
        rst      = 1'b0;
        in_reset = 1'b1;
        sb.delete();
        #1;
        chk("midrst_rgb", rgb, 12'h000);
        chk("midrst_de", 12'(de_o), 12'h0);
        chk("midrst_fs", 12'(frame_start), 12'h0);
        chk("midrst_hsync", 12'(hsync_o), 12'h1);
        chk("midrst_vsync", 12'(vsync_o), 12'h1);
    endtask

    task automatic run_frame(input int chg_line, input logic [1:0] chg_sel, input int rst_line);
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                if (y == chg_line && x == 0) pat_sel = chg_sel;
                if (y == rst_line && x == 20) do_reset_check();
                if (in_reset && y == VV + 1 && x == 5) rel_pend = 1'b1;
                drive_pixel(x, y);
            end
        end
    endtask

    // Monitor: every cycle the pipeline is full, compare the DUT outputs with the oldest expectation
    initial begin
        exp_t e;
        int   shown;
        shown = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                tests++;
                if ({rgb, hsync_o, vsync_o, de_o, frame_start} !== e) begin
                    fails++;
                    if (shown < 30) begin
                        shown++;
                        $display("FAIL pixel @%0t: got rgb=%h hs=%b vs=%b de=%b fs=%b expected rgb=%h hs=%b vs=%b de=%b fs=%b",
                                 $time, rgb, hsync_o, vsync_o, de_o, frame_start,
                                 e.rgb, e.hs, e.vs, e.de, e.fs);
                    end
                end
            end
        end
    end

    initial begin
        rst         = 1'b0;
        in_reset    = 1'b1;
        rel_pend    = 1'b0;
        xpos        = 12'd0;
        ypos        = 12'd0;
        disp_active = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        h_visible   = 12'(HV);
        v_visible   = 12'(VV);
        bar_width   = 12'd5;
        pat_sel     = 2'd1;
        solid_rgb   = 12'hA5C;
        model_reset();

        repeat (3) @(negedge clk);
        #1;
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_de", 12'(de_o), 12'h0);
        chk("rst_fs", 12'(frame_start), 12'h0);
        chk("rst_hsync", 12'(hsync_o), 12'h1);
        chk("rst_vsync", 12'(vsync_o), 12'h1);
        rel_pend = 1'b1;

        run_frame(-1, 2'd0, -1);
        pat_sel = 2'd2;
        run_frame(-1, 2'd0, -1);
        run_frame(20, 2'd0, -1);
        pat_sel   = 2'd1;
        bar_width = 12'd1;
        run_frame(-1, 2'd0, -1);
        pat_sel = 2'd3;
        repeat (11) run_frame(-1, 2'd0, -1);

        pat_sel = 2'd2;
        run_frame(-1, 2'd0, -1);
        pat_sel   = 2'd1;
        solid_rgb = 12'h3C7;
        run_frame(-1, 2'd0, 10);
        run_frame(-1, 2'd0, -1);
        run_frame(-1, 2'd0, -1);

        repeat (4) begin
            solid_rgb = 12'($urandom);
            bar_width = 12'($urandom_range(1, 12));
            run_frame($urandom_range(0, VV - 1), 2'($urandom_range(0, 3)), -1);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
